// File: rtl/bcd_scan_counter.sv
// Four-digit up/down BCD counter with prescaled stepping and a multiplexed
// digit scan output. Define BCD_SCAN_BLANK_EN to blank leading zero digits.
module bcd_scan_counter #(
    parameter int PRESCALE = 50000,
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up_dn,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        carry,
    output logic [3:0]  num,
    output logic [3:0]  dig_sel
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   count_q, count_d;
    logic          carry_q, carry_d;
    logic          step;
    logic [15:0]   stepped;
    logic          wrap;
    logic [15:0]   load_clean;
    logic          blank;

    // One BCD step with ripple carry/borrow; bit 16 flags full wrap.
    function automatic logic [16:0] bcd_step(input logic [15:0] v,
                                              input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (v[i*4 +: 4] >= 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[i*4 +: 4] == 4'd0) begin
                        r[i*4 +: 4] = 4'd9;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    // Loaded nibbles outside 0-9 are forced to zero.
    function automatic logic [15:0] bcd_clean(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd0 : v[i*4 +: 4];
        end
        return r;
    endfunction

    assign step       = en && (presc_q == PW'(PRESCALE - 1));
    assign {wrap, stepped} = bcd_step(count_q, up_dn);
    assign load_clean = bcd_clean(load_val);

    // Next-state for prescaler, count and wrap pulse (clr > load > step).
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        carry_d = 1'b0;
        if (clr) begin
            presc_d = '0;
            count_d = '0;
        end else if (load) begin
            presc_d = '0;
            count_d = load_clean;
        end else if (en) begin
            if (step) begin
                presc_d = '0;
                count_d = stepped;
                carry_d = wrap;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Free-running scan divider and digit index.
    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            carry_q <= carry_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
        end
    end

`ifdef BCD_SCAN_BLANK_EN
    // Blank a digit slot when it and every digit above it are zero.
    always_comb begin
        blank = 1'b0;
        unique case (idx_q)
            2'd0: blank = 1'b0;
            2'd1: blank = (count_q[15:4] == 12'd0);
            2'd2: blank = (count_q[15:8] == 8'd0);
            2'd3: blank = (count_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    // Every slot is always enabled.
    always_comb begin
        blank = 1'b0;
    end
`endif

    // Display outputs decoded from registered state only.
    always_comb begin
        num     = count_q[{idx_q, 2'b00} +: 4];
        dig_sel = blank ? 4'b0000 : (4'b0001 << idx_q);
    end

    assign count = count_q;
    assign carry = carry_q;

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000: clk cycles per count step; legal range >= 1.
REQ-002 SHALL have parameter SCAN_DIV, default 1000: clk cycles per display digit slot; legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: count enable; gates the prescaler.
REQ-006 SHALL have port up_dn, input, 1 bit: count direction; 1 = up, 0 = down.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear of the count.
REQ-008 SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-009 SHALL have port load_val, input, 16 bits: four BCD digits; [3:0] is the ones digit.
REQ-010 SHALL have port count, output, 16 bits: current four-digit BCD count.
REQ-011 SHALL have port carry, output, 1 bit: one-cycle pulse on wrap-around in either direction.
REQ-012 SHALL have port num, output, 4 bits: BCD digit for the active scan slot; feeds the 7-segment decoder num input.
REQ-013 SHALL have port dig_sel, output, 4 bits: one-hot, active-high digit enable; bit i selects digit i.

Function
REQ-014 SHALL use a prescaler counter: when en=1 it increments each cycle; on the edge where it equals PRESCALE-1 it wraps to 0 and the count steps one in the up_dn direction; when en=0 it holds.
REQ-015 SHALL count in BCD per digit with ripple carry/borrow (0019 up -> 0020; 0100 down -> 0099); each count nibble SHALL always be in the range 0-9.
REQ-016 SHALL wrap 9999 up to 0000 and 0000 down to 9999; carry SHALL be 1 for exactly the cycle after that step edge, and 0 otherwise.
REQ-017 SHALL apply per-edge priority rst > clr > load > step; clr zeroes count and the prescaler; load copies load_val into count and zeroes the prescaler; neither asserts carry.
REQ-018 SHALL replace any load_val nibble greater than 9 with 0 on load (for example 16'h12F4 loads as 0x1204).
REQ-019 SHALL use a scan divider counting 0..SCAN_DIV-1, independent of en; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-020 SHALL drive num combinationally as count nibble[index] and dig_sel as 1<<index, both decoded from registers only so they are glitch-free.
REQ-021 SHALL reflect a count change on num in the same cycle the count updates when the changed digit is the one currently selected.
REQ-022 SHALL leave the up_dn value irrelevant on cycles without a step; a direction change takes effect on the next step.

Reset
REQ-023 SHALL, on the rising clk edge with rst=1, set count=0, prescaler=0, scan divider=0, index=0, carry=0; after that edge outputs are num=0 and dig_sel=4'b0001.
REQ-024 SHALL let rst asserted mid-step override clr, load, and the step, and SHALL suppress carry.

Configuration
REQ-025 SHALL implement leading-zero blanking when macro BCD_SCAN_BLANK_EN is defined: dig_sel SHALL be 4'b0000 during the slot of any leading zero digit (digits above the most significant nonzero digit); digit 0 is never blanked; num is unchanged.
REQ-026 SHALL, without BCD_SCAN_BLANK_EN, always drive dig_sel one-hot per REQ-020.

Verification (bench uses PRESCALE=4, SCAN_DIV=2)
REQ-027 SHALL cover: rst=1 for 2 cycles then en=1, up_dn=1 -> count=0001 after 4 enabled cycles, 0002 after 8, carry=0 throughout.
REQ-028 SHALL cover: load_val=16'h9999, load=1 then en=1, up_dn=1 -> count=0000 after 4 cycles, with carry=1 for one cycle.
REQ-029 SHALL cover: load_val=16'h0000, up_dn=0, en=1 -> count=9999 after 4 cycles, with carry=1 for one cycle; load_val=16'h12F4 -> count=1204.
REQ-030 SHALL cover: clr and load asserted together with a step due -> count=0000, carry=0; en=0 for 20 cycles -> count stable.
REQ-031 SHALL cover: count=1234 loaded -> dig_sel sequences 0001, 0010, 0100, 1000 at 2 cycles per slot, with num=4, 3, 2, 1 respectively.
REQ-032 SHALL cover, with BCD_SCAN_BLANK_EN defined: count=0042 -> dig_sel=0000 in slots 2 and 3, and 0001 and 0010 in slots 0 and 1; count=0000 -> only slot 0 is enabled.
